// File: rtl/nbout_pkg.sv
`default_nettype none
// nbout_pkg: shared types and default widths for the NBout slice controller.
// Rev 1.0
package nbout_pkg;

    localparam int DEF_N          = 16;
    localparam int DEF_TN         = 1;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_PASS_W     = 8;
    localparam int DEF_PIPE_LAT   = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic                      valid;
        logic [DEF_ADDR_WIDTH-1:0] addr;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/nbout_mem.sv
`default_nettype none
// nbout_mem: NBout register file, one sync write port, one registered read port
// with write-to-read bypass. Rev 1.0
module nbout_mem
    import nbout_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WIDTH      = DEF_N * DEF_TN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/nbout_ctrl_slice.sv
`default_nettype none
// nbout_ctrl_slice: NBout buffer and sequencer for one NFU slice.
// Optional bias preload port under NBOUT_BIAS_EN. Rev 1.0
module nbout_ctrl_slice
    import nbout_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int Tn         = DEF_TN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int PASS_W     = DEF_PASS_W,
    parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef NBOUT_BIAS_EN
    input  logic                  i_bias_we,
    input  logic [ADDR_WIDTH-1:0] i_bias_addr,
    input  logic [N*Tn-1:0]       i_bias_data,
`endif
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_num_out,
    input  logic [PASS_W-1:0]     i_num_pass,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic                  o_issue_valid,
    output logic [N*Tn-1:0]       o_nbout,
    input  logic [N*Tn-1:0]       i_result,
    output logic [N*Tn-1:0]       o_edram_data,
    output logic                  o_edram_valid,
    input  logic                  i_edram_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int W = N * Tn;

    state_t                state, state_nx;
    logic [ADDR_WIDTH:0]   num_out_q;
    logic [PASS_W-1:0]     num_pass_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic [PASS_W-1:0]     pass_cnt;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_addr;
    slot_t                 dl [PIPE_LAT];
    logic [ADDR_WIDTH:0]   drain_addr;
    logic                  edram_valid;

    logic                  hazard, accept, last_addr, last_pass, line_empty;
    logic                  drain_hs, drain_last, rd_en, wr_en;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [W-1:0]          wr_data, rd_data;

    // The last slot is excluded from the hazard: it writes on the same edge
    // the read happens, and the memory bypass returns the fresh value.
    always_comb begin
        hazard     = issue_valid && (issue_addr == addr);
        line_empty = !issue_valid;
        for (int i = 0; i < PIPE_LAT; i++) begin
            if (dl[i].valid) begin
                line_empty = 1'b0;
                if ((i < PIPE_LAT - 1) && (dl[i].addr == addr)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign o_in_ready = (state == ACCUM) && !hazard;
    assign accept     = o_in_ready && i_in_valid;
    assign last_addr  = ({1'b0, addr} == (num_out_q - (ADDR_WIDTH+1)'(1)));
    assign last_pass  = (pass_cnt == (num_pass_q - PASS_W'(1)));
    assign drain_hs   = edram_valid && i_edram_ready;
    assign drain_last = (drain_addr == num_out_q);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx = ((i_num_out == '0) || (i_num_pass == '0)) ? DONE : ACCUM;
                end
            end
            ACCUM:   if (accept && last_addr && last_pass) state_nx = FLUSH;
            FLUSH:   if (line_empty) state_nx = DRAIN;
            DRAIN:   if (drain_hs && drain_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_out_q   <= '0;
            num_pass_q  <= '0;
            addr        <= '0;
            pass_cnt    <= '0;
            issue_valid <= 1'b0;
            issue_addr  <= '0;
            drain_addr  <= '0;
            edram_valid <= 1'b0;
        end else begin
            issue_valid <= accept;
            if ((state == IDLE) && i_start) begin
                num_out_q  <= i_num_out;
                num_pass_q <= i_num_pass;
                addr       <= '0;
                pass_cnt   <= '0;
                drain_addr <= '0;
            end
            if (accept) begin
                issue_addr <= addr;
                if (last_addr) begin
                    addr     <= '0;
                    pass_cnt <= pass_cnt + PASS_W'(1);
                end else begin
                    addr <= addr + ADDR_WIDTH'(1);
                end
            end
            // drain_addr always points at the next entry to fetch.
            if ((state == FLUSH) && line_empty) begin
                edram_valid <= 1'b1;
                drain_addr  <= (ADDR_WIDTH+1)'(1);
            end else if ((state == DRAIN) && drain_hs) begin
                if (drain_last) begin
                    edram_valid <= 1'b0;
                end else begin
                    drain_addr <= drain_addr + (ADDR_WIDTH+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= '{valid: issue_valid, addr: issue_addr};
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    assign rd_en = accept
                || ((state == FLUSH) && line_empty)
                || ((state == DRAIN) && drain_hs && !drain_last);
    assign rd_addr = (state == ACCUM) ? addr : drain_addr[ADDR_WIDTH-1:0];

    always_comb begin
        wr_en   = dl[PIPE_LAT-1].valid;
        wr_addr = dl[PIPE_LAT-1].addr;
        wr_data = i_result;
`ifdef NBOUT_BIAS_EN
        if ((state == IDLE) && i_bias_we) begin
            wr_en   = 1'b1;
            wr_addr = i_bias_addr;
            wr_data = i_bias_data;
        end
`endif
    end

    nbout_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

`ifdef NBOUT_BIAS_EN
    assign o_nbout = issue_valid ? rd_data : '0;
`else
    logic pass0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass0_q <= 1'b0;
        end else if (accept) begin
            pass0_q <= (pass_cnt == '0);
        end
    end

    assign o_nbout = (issue_valid && !pass0_q) ? rd_data : '0;
`endif

    assign o_issue_valid = issue_valid;
    assign o_edram_valid = edram_valid;
    assign o_edram_data  = edram_valid ? rd_data : '0;
    assign o_busy        = (state != IDLE);
    assign o_done        = (state == DONE);

endmodule
`default_nettype wire
